// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Operand-fetch stage of the 16-bit pipeline, between decode and
//            the ALU. Drives the register-file read addresses, forwards
//            same-cycle writeback data around the file, tracks in-flight
//            destination registers with a scoreboard and hands the operand
//            bundle to execute through a one-entry valid/ready register.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       decode handshake (in_ready independent of
//                             in_valid)
//   in_src0/1, in_use0/1      source register addresses and read enables
//   in_dst, in_wr             destination register and its write enable
//   in_op                     ALU select code, passed through
//   in_imm, in_use_imm        immediate and operand-B immediate select
//   rd0/1_addr, rd0/1_data    register-file read ports (combinational data)
//   wb_en, wb_addr, wb_data   writeback bus shared with the file write port
//   out_valid / out_ready     execute handshake
//   out_a, out_b, out_op,
//   out_dst, out_wr           registered operand bundle
//   busy                      scoreboard, bit i = register i write pending
// ============================================================================
module operand_fetch #(
  parameter int DW = 16,
  parameter int NR = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_src0,
  input  logic [AW-1:0] in_src1,
  input  logic          in_use0,
  input  logic          in_use1,
  input  logic [AW-1:0] in_dst,
  input  logic          in_wr,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,

  output logic [AW-1:0] rd0_addr,
  output logic [AW-1:0] rd1_addr,
  input  logic [DW-1:0] rd0_data,
  input  logic [DW-1:0] rd1_data,

  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,

  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [3:0]    out_op,
  output logic [AW-1:0] out_dst,
  output logic          out_wr,

  output logic [NR-1:0] busy
);

  // --------------------------------------------------------------------------
  // Register-file read addresses follow the decoded sources directly so the
  // file's combinational read data is available in the same cycle.
  // --------------------------------------------------------------------------
  assign rd0_addr = in_src0;
  assign rd1_addr = in_src1;

  // --------------------------------------------------------------------------
  // Writeback address matches against the three register fields.
  // --------------------------------------------------------------------------
  logic wb_hit0;
  logic wb_hit1;
  logic wb_hit_dst;

  assign wb_hit0    = wb_en && (wb_addr == in_src0);
  assign wb_hit1    = wb_en && (wb_addr == in_src1);
  assign wb_hit_dst = wb_en && (wb_addr == in_dst);

  // --------------------------------------------------------------------------
  // Operand selection. The file is written on the same edge that captures
  // the operands, so a matching writeback must bypass the stale read data.
  // Unused sources are forced to zero to keep the bundle deterministic.
  // --------------------------------------------------------------------------
  logic [DW-1:0] op0;
  logic [DW-1:0] op1;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;

  always_comb begin
    op0 = '0;
    if (in_use0) begin
      op0 = wb_hit0 ? wb_data : rd0_data;
    end
  end

  always_comb begin
    op1 = '0;
    if (in_use1) begin
      op1 = wb_hit1 ? wb_data : rd1_data;
    end
  end

  assign opnd_a = op0;
  assign opnd_b = in_use_imm ? in_imm : op1;

  // --------------------------------------------------------------------------
  // Hazard detection. A register is still pending when its busy bit is set
  // and the writeback this cycle is not retiring it; a same-cycle writeback
  // resolves the dependency because its data is forwarded above.
  // Operand B read through src1 is irrelevant when the immediate is used.
  // The destination check blocks a second in-flight write to the same
  // register (WAW) so each busy bit tracks at most one outstanding writer.
  // --------------------------------------------------------------------------
  logic pend0;
  logic pend1;
  logic pend_dst;
  logic raw0;
  logic raw1;
  logic waw;
  logic hazard;

  assign pend0    = busy[in_src0] && !wb_hit0;
  assign pend1    = busy[in_src1] && !wb_hit1;
  assign pend_dst = busy[in_dst]  && !wb_hit_dst;

  assign raw0   = in_use0 && pend0;
  assign raw1   = in_use1 && !in_use_imm && pend1;
  assign waw    = in_wr && pend_dst;
  assign hazard = raw0 || raw1 || waw;

  // --------------------------------------------------------------------------
  // Handshake. The output slot can take a new bundle when it is empty or
  // being drained this cycle. in_ready deliberately excludes in_valid so
  // that no combinational loop can form through the upstream handshake.
  // --------------------------------------------------------------------------
  logic slot_free;
  logic fire;
  logic drain;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard;
  assign fire      = in_valid && in_ready;
  assign drain     = out_valid && out_ready && !fire;

  // --------------------------------------------------------------------------
  // Output register. The payload is only written on fire; when the bundle
  // drains without replacement the payload keeps its last value and only
  // out_valid drops.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_dst   <= '0;
      out_wr    <= 1'b0;
    end else begin
      if (fire) begin
        out_valid <= 1'b1;
        out_a     <= opnd_a;
        out_b     <= opnd_b;
        out_op    <= in_op;
        out_dst   <= in_dst;
        out_wr    <= in_wr;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard. Each bit is cleared by a writeback to its register and set
  // by an accepted instruction that writes it. OR-ing the set vector after
  // masking with the clear vector lets a new writer win over a retiring one
  // when both target the same register in the same cycle.
  // A writeback to a register that is not busy simply leaves the bit at 0.
  // --------------------------------------------------------------------------
  logic [NR-1:0] sb_clr;
  logic [NR-1:0] sb_set;
  logic [NR-1:0] busy_next;

  for (genvar i = 0; i < NR; i++) begin : g_sb
    localparam logic [AW-1:0] IDX = AW'(i);
    assign sb_clr[i] = wb_en && (wb_addr == IDX);
    assign sb_set[i] = fire && in_wr && (in_dst == IDX);
  end

  assign busy_next = (busy & ~sb_clr) | sb_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule
`default_nettype wire
